// File: rtl/orion_mem_responder_pkg.sv
// orion_mem_responder_pkg: shared types and constants for the memory responder
package orion_mem_responder_pkg;
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ACK} mem_resp_state_t;
  localparam int MEM_DEPTH_WORDS_DEFAULT = 4096;
endpackage

// File: rtl/orion_bytemask_ram.sv
// orion_bytemask_ram: single-port read-first synchronous RAM with per-byte write enables
module orion_bytemask_ram #(
  parameter int DATAW = 32,
  parameter int MASKW = DATAW / 8,
  parameter int DEPTH = 4096,
  parameter int IW = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [MASKW-1:0] mask,
  input  logic [IW-1:0]    idx,
  input  logic [DATAW-1:0] wdata,
  output logic [DATAW-1:0] rdata
);
  logic [DATAW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= r_mem[idx];
      for (int i = 0; i < MASKW; i++)
        if (we && mask[i]) r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/orion_mem_responder.sv
// orion_mem_responder: fixed-latency byte-maskable memory responder for the core request bus
module orion_mem_responder
  import orion_mem_responder_pkg::*;
#(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int MASKW = DATAW / 8,
  parameter int DEPTH_WORDS = MEM_DEPTH_WORDS_DEFAULT,
  parameter int LATENCY = 2,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic             valid,
  input  logic [DATAW-1:0] wdata,
  input  logic [MASKW-1:0] mask,
  input  logic             we,
  output logic [DATAW-1:0] rdata,
  output logic             ack,
  output logic             err
);
  localparam int BW = $clog2(MASKW);
  localparam int IW = $clog2(DEPTH_WORDS);
  mem_resp_state_t  r_state;
  logic [3:0]       r_cnt;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_wdata;
  logic [DATAW-1:0] r_rdata;
  logic [MASKW-1:0] r_mask;
  logic             r_we;
  logic             r_ack;
  logic             r_err;
  logic             r_use_ram;
  logic             w_idle;
  logic             w_accept;
  logic             w_go;
  logic             w_oor;
  logic [ADDRW-1:0] w_addr;
  logic [ADDRW-1:0] w_widx;
  logic [DATAW-1:0] w_wdata;
  logic [MASKW-1:0] w_mask;
  logic             w_we;
  logic [DATAW-1:0] w_ram_rdata;
  // with LATENCY=1 the access happens at the accepting edge, so the live inputs are used
  assign w_idle   = r_state == MEM_IDLE;
  assign w_accept = w_idle && valid;
  assign w_addr   = w_idle ? addr : r_addr;
  assign w_wdata  = w_idle ? wdata : r_wdata;
  assign w_mask   = w_idle ? mask : r_mask;
  assign w_we     = w_idle ? we : r_we;
  assign w_widx   = w_addr >> BW;
  assign w_oor    = w_widx >= ADDRW'(DEPTH_WORDS);
  assign w_go     = w_idle ? (valid && LATENCY == 1) : (r_state == MEM_WAIT && r_cnt == 4'd0);
  // RAM output is live only in the ack cycle of an in-range read, then latched into r_rdata
  assign rdata    = r_use_ram ? w_ram_rdata : r_rdata;
  assign ack      = r_ack;
  assign err      = r_err;
  orion_bytemask_ram #(
    .DATAW(DATAW), .MASKW(MASKW), .DEPTH(DEPTH_WORDS), .IW(IW), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(clk),
    .en(w_go && !w_oor),
    .we(w_we),
    .mask(w_mask),
    .idx(w_widx[IW-1:0]),
    .wdata(w_wdata),
    .rdata(w_ram_rdata)
  );
  // capture the request fields when it is accepted
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_mask  <= mask;
      r_we    <= we;
    end
  end
  // request FSM: accept, count down the latency, pulse ack/err for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MEM_IDLE;
      r_cnt     <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_use_ram <= 1'b0;
    end else begin
      r_ack     <= w_go;
      r_err     <= w_go && w_oor;
      r_use_ram <= w_go && !w_we && !w_oor;
      r_rdata   <= r_use_ram ? w_ram_rdata : (w_go && !w_we && w_oor) ? '0 : r_rdata;
      r_cnt     <= w_accept ? 4'(LATENCY - 2) : (r_state == MEM_WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      r_state   <= w_go ? MEM_ACK : w_accept ? MEM_WAIT : (r_state == MEM_ACK) ? MEM_IDLE : r_state;
    end
  end
  // a master must keep valid asserted while its request is pending
  always_ff @(posedge clk) begin
    if (!rst && r_state == MEM_WAIT) assert (valid);
  end
endmodule

// File: tb/tb_orion_mem_responder.sv
// tb_orion_mem_responder: directed and random checks of four responders at latencies 1, 2, 4, 15
module tb_orion_mem_responder;
  localparam int LATS [4] = '{1, 2, 4, 15};
  localparam int WIN = 64;
  logic        clk = 1'b0;
  logic [3:0]  rst;
  logic [31:0] addr [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];
  logic [3:0]  mask [4];
  logic [3:0]  valid, we, ack, err;
  logic [31:0] mdl [4][WIN];
  logic [31:0] last_rd [4];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    orion_mem_responder #(.LATENCY(LATS[g])) u_dut (
      .clk(clk), .rst(rst[g]), .addr(addr[g]), .valid(valid[g]), .wdata(wdata[g]),
      .mask(mask[g]), .we(we[g]), .rdata(rdata[g]), .ack(ack[g]), .err(err[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
    int n;
    int idx;
    logic [31:0] bm;
    logic [31:0] exp_rd;
    addr[d] = a; wdata[d] = wd; mask[d] = m; we[d] = w; valid[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[d] && n < 20);
    valid[d] = 1'b0;
    chk("latency", n, LATS[d]);
    if (!ack[d]) return;
    ack_cyc = cyc;
    idx = int'(a >> 2);
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    if (idx >= 4096) begin
      if (!w) last_rd[d] = 32'h0;
    end else if (w) mdl[d][idx] = (mdl[d][idx] & ~bm) | (wd & bm);
    else last_rd[d] = mdl[d][idx];
    exp_rd = last_rd[d];
    chk("err", err[d], idx >= 4096);
    chk("rdata", rdata[d], exp_rd);
    @(posedge clk); #1;
    chk("ack_after", ack[d], 1'b0);
    chk("rdata_hold", rdata[d], exp_rd);
  endtask
  initial begin
    int c0;
    logic [31:0] old5;
    rst = 4'hF; valid = 4'h0; we = 4'h0;
    for (int d = 0; d < 4; d++) begin
      addr[d] = '0; wdata[d] = '0; mask[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_ack", ack[d], 1'b0);
      chk("rst_err", err[d], 1'b0);
      chk("rst_rdata", rdata[d], 32'h0);
    end
    rst = 4'h0;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < WIN; i++) xact(d, 1'b1, 32'(i << 2), $urandom, 4'hF);
    xact(1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("read_deadbeef", rdata[1], 32'hDEADBEEF);
    xact(1, 1'b1, 32'h40, 32'h11223344, 4'b0101);
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("merge", rdata[1], 32'hDE22BE44);
    xact(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
    c0 = ack_cyc;
    xact(1, 1'b0, 32'h80, 32'h0, 4'h0);
    chk("b2b_gap", ack_cyc - c0, LATS[1] + 1);
    chk("read_cafe", rdata[1], 32'hCAFEF00D);
    xact(1, 1'b0, 32'h4000, 32'h0, 4'h0);
    xact(1, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'hF);
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0);
    old5 = mdl[2][5];
    addr[2] = 32'h14; wdata[2] = ~old5; mask[2] = 4'hF; we[2] = 1'b1; valid[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b1; valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    last_rd[2] = 32'h0;
    chk("midrst_ack", ack[2], 1'b0);
    chk("midrst_err", err[2], 1'b0);
    chk("midrst_rdata", rdata[2], 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_noack", ack[2], 1'b0);
    end
    xact(2, 1'b0, 32'h14, 32'h0, 4'h0);
    chk("midrst_word", rdata[2], old5);
    xact(0, 1'b1, 32'h8, 32'h12345678, 4'h0);
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0);
    xact(3, 1'b1, 32'hC, 32'h12345678, 4'h0);
    xact(3, 1'b0, 32'hC, 32'h0, 4'h0);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 40; k++)
        xact(d, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0 ? 32'($urandom_range(4096, 8191)) : 32'($urandom_range(0, WIN - 1))) * 4
               + 32'($urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
